// File: rtl/comb_sweep_pkg.sv
// rtl/comb_sweep_pkg.sv - shared types and width helpers for the comb_sweep engine
// No ports: state encoding plus the truth-table and settle-counter width helpers.
package comb_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int N_IN_MAX = 6;

  // One truth-table bit per input pattern.
  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  // clog2(settle), floored at 1 so SETTLE=1 still gets a real counter bit.
  function automatic int cnt_width(input int settle);
    int w;
    w = 1;
    while ((1 << w) < settle) w++;
    return w;
  endfunction

endpackage

// File: rtl/comb_sweep_first_diff.sv
// rtl/comb_sweep_first_diff.sv - lowest-set-bit priority encoder over a difference vector
// diff_i : per-pattern mismatch flags (captured ^ expected)
// idx_o  : index of the lowest set flag, 0 when none set
// any_o  : at least one flag set
module first_diff
  import comb_sweep_pkg::*;
#(
  parameter  int N_IN = 3,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic [TT_W-1:0] diff_i,
  output logic [N_IN-1:0] idx_o,
  output logic            any_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = |diff_i;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (diff_i[i]) idx_o = N_IN'(i);
    end
  end

endmodule

// File: rtl/comb_sweep.sv
// rtl/comb_sweep.sv - exhaustive stimulus/response sweep of a small combinational block
// clk, rst_n   : clock, asynchronous active-low reset
// start        : sweep request, honoured only when idle
// expect_tt    : expected truth table, latched on accepted start
// vec_out      : pattern driven to the block under test (MSB = first input)
// f_in         : response of the block under test
// tt_out       : captured truth table
// busy, done   : sweep in progress / one-cycle end-of-sweep pulse
// pass         : captured table equals latched expectation
// mismatch_idx : lowest differing pattern index, 0 on pass
module comb_sweep
  import comb_sweep_pkg::*;
#(
  parameter  int N_IN   = 3,
  parameter  int SETTLE = 2,
  localparam int TT_W   = tt_width(N_IN),
  localparam int IDX_W  = N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [TT_W-1:0]  expect_tt,
  output logic [N_IN-1:0]  vec_out,
  input  logic             f_in,
  output logic [TT_W-1:0]  tt_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] mismatch_idx
);

  localparam int                CNT_W    = cnt_width(SETTLE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TT_W-1:0]    exp_q, exp_d;
  logic [TT_W-1:0]    tt_q, tt_d;
  logic               pass_q, pass_d;
  logic [IDX_W-1:0]   mm_q, mm_d;
  logic [N_IN-1:0]    vec_q;
  logic               busy_q, done_q;

  // Table as it will look after the current sample; on the last sample this
  // lets pass/mismatch register on the same edge that raises done.
  logic [TT_W-1:0]    tt_smp;
  logic [IDX_W-1:0]   fd_idx;
  logic               fd_any;

  always_comb begin
    tt_smp         = tt_q;
    tt_smp[idx_q]  = f_in;
  end

  first_diff #(.N_IN(N_IN)) u_first_diff (
    .diff_i (tt_smp ^ exp_q),
    .idx_o  (fd_idx),
    .any_o  (fd_any)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    pass_d  = pass_q;
    mm_d    = mm_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d   = expect_tt;
          tt_d    = '0;
          pass_d  = 1'b0;
          mm_d    = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        tt_d = tt_smp;
        if (idx_q == LAST_IDX) begin
          pass_d  = ~fd_any;
          mm_d    = fd_idx;
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      pass_q  <= 1'b0;
      mm_q    <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
      // Status outputs are registered from the next state so they line up
      // with the state they describe rather than lagging it by a cycle.
      busy_q  <= (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
      done_q  <= (state_d == ST_FINISH);
      vec_q   <= ((state_d == ST_SETTLE) || (state_d == ST_SAMPLE)) ? idx_d : '0;
    end
  end

  assign vec_out      = vec_q;
  assign tt_out       = tt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_idx = mm_q;

endmodule

// File: tb/tb_comb_sweep.sv
// tb/tb_comb_sweep.sv - self-checking bench for comb_sweep (3-input and 2-input builds)
module tb_comb_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic       start3;
  logic [7:0] exp3;
  logic [2:0] vec3;
  logic       f3;
  logic [7:0] tt3;
  logic       busy3, done3, pass3;
  logic [2:0] mm3;
  logic [7:0] lut3;

  logic       start2;
  logic [3:0] exp2;
  logic [1:0] vec2;
  logic       f2;
  logic [3:0] tt2;
  logic       busy2, done2, pass2;
  logic [1:0] mm2;
  logic [3:0] lut2;

  // Block under test modelled as a lookup table indexed by the applied pattern.
  assign f3 = lut3[vec3];
  assign f2 = lut2[vec2];

  comb_sweep #(.N_IN(3), .SETTLE(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expect_tt(exp3),
    .vec_out(vec3), .f_in(f3), .tt_out(tt3), .busy(busy3),
    .done(done3), .pass(pass3), .mismatch_idx(mm3)
  );

  comb_sweep #(.N_IN(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .expect_tt(exp2),
    .vec_out(vec2), .f_in(f2), .tt_out(tt2), .busy(busy2),
    .done(done2), .pass(pass2), .mismatch_idx(mm2)
  );

  int vecs = 0;
  int errs = 0;

  function automatic int lowest_set(input logic [7:0] d);
    for (int i = 0; i < 8; i++) if (d[i]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start3 = 1'b0; start2 = 1'b0;
    exp3 = '0; exp2 = '0; lut3 = '0; lut2 = '0;
    #12;
    vecs++;
    if ({vec3, tt3, busy3, done3, pass3, mm3} !== 16'd0) begin
      errs++;
      $display("FAIL reset3 got vec=%0d tt=%h busy=%b done=%b pass=%b mm=%0d want all 0",
               vec3, tt3, busy3, done3, pass3, mm3);
    end
    vecs++;
    if ({vec2, tt2, busy2, done2, pass2, mm2} !== 11'd0) begin
      errs++;
      $display("FAIL reset2 got vec=%0d tt=%h busy=%b done=%b pass=%b mm=%0d want all 0",
               vec2, tt2, busy2, done2, pass2, mm2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (busy3 !== 1'b0 || done3 !== 1'b0) begin
      errs++;
      $display("FAIL idle_no_start got busy=%b done=%b want 0/0", busy3, done3);
    end
  endtask

  // Full 3-input sweep. Edge k is counted from the accepting edge E0 (k=0).
  // restart_k >= 0 pulses start again after that edge.
  task automatic sweep3(input string name, input logic [7:0] lut, input logic [7:0] ex,
                        input int restart_k);
    logic       eb, ed;
    logic [2:0] ev;
    int         ndone;
    ndone = 0;
    @(negedge clk);
    lut3 = lut; exp3 = ex; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int k = 0; k <= 26; k++) begin
      eb = (k < 24);
      ed = (k == 24);
      ev = (k < 24) ? 3'(k / 3) : 3'd0;
      if (done3) ndone++;
      vecs++;
      if ({busy3, done3, vec3} !== {eb, ed, ev}) begin
        errs++;
        $display("FAIL %s k=%0d busy/done/vec got %b/%b/%0d want %b/%b/%0d",
                 name, k, busy3, done3, vec3, eb, ed, ev);
      end
      start3 = (k == restart_k);
      @(posedge clk); #1;
    end
    start3 = 1'b0;
    vecs++;
    if (ndone !== 1) begin
      errs++;
      $display("FAIL %s done_count got %0d want 1", name, ndone);
    end
    vecs++;
    if (tt3 !== lut) begin
      errs++;
      $display("FAIL %s tt_out got %h want %h", name, tt3, lut);
    end
    vecs++;
    if (pass3 !== (lut == ex)) begin
      errs++;
      $display("FAIL %s pass got %b want %b", name, pass3, (lut == ex));
    end
    vecs++;
    if (mm3 !== 3'(lowest_set(lut ^ ex))) begin
      errs++;
      $display("FAIL %s mismatch_idx got %0d want %0d", name, mm3, lowest_set(lut ^ ex));
    end
  endtask

  task automatic sweep2(input string name, input logic [3:0] lut, input logic [3:0] ex);
    logic       eb, ed;
    logic [1:0] ev;
    @(negedge clk);
    lut2 = lut; exp2 = ex; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      eb = (k < 8);
      ed = (k == 8);
      ev = (k < 8) ? 2'(k / 2) : 2'd0;
      vecs++;
      if ({busy2, done2, vec2} !== {eb, ed, ev}) begin
        errs++;
        $display("FAIL %s k=%0d busy/done/vec got %b/%b/%0d want %b/%b/%0d",
                 name, k, busy2, done2, vec2, eb, ed, ev);
      end
      @(posedge clk); #1;
    end
    vecs++;
    if ({tt2, pass2, mm2} !== {lut, (lut == ex), 2'(lowest_set({4'd0, lut ^ ex}))}) begin
      errs++;
      $display("FAIL %s tt/pass/mm got %h/%b/%0d want %h/%b/%0d", name, tt2, pass2, mm2,
               lut, (lut == ex), lowest_set({4'd0, lut ^ ex}));
    end
  endtask

  task automatic test_directed();
    sweep3("parity",      8'h96, 8'h96, -1);
    sweep3("wrong_exp",   8'h96, 8'h97, -1);
    sweep3("single_bit",  8'h96, 8'hD6, -1);
    sweep3("busy_protect", 8'h96, 8'h96, 5);
  endtask

  task automatic test_reset_mid();
    logic [7:0] partial;
    @(negedge clk);
    lut3 = 8'h96; exp3 = 8'h96; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    // Patterns 0..2 are sampled at edges 3, 6 and 9.
    partial = 8'h96 & 8'h07;
    vecs++;
    if (tt3 !== partial || busy3 !== 1'b1) begin
      errs++;
      $display("FAIL mid_partial got tt=%h busy=%b want %h/1", tt3, busy3, partial);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({busy3, vec3, tt3, done3} !== 13'd0) begin
      errs++;
      $display("FAIL async_reset got busy=%b vec=%0d tt=%h done=%b want 0", busy3, vec3, tt3, done3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sweep3("after_reset", 8'h96, 8'h96, -1);
  endtask

  task automatic test_param_variant();
    sweep2("and2", 4'b1000, 4'b1000);
    sweep2("and2_bad", 4'b1000, 4'b1010);
  endtask

  task automatic test_random();
    logic [7:0] l, e;
    logic [3:0] l2, e2;
    for (int n = 0; n < 8; n++) begin
      l = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       e = l;
        1:       e = l ^ (8'd1 << $urandom_range(0, 7));
        default: e = 8'($urandom);
      endcase
      sweep3($sformatf("rand3_%0d", n), l, e, -1);
    end
    for (int n = 0; n < 4; n++) begin
      l2 = 4'($urandom);
      e2 = ($urandom_range(0, 1) == 0) ? l2 : 4'($urandom);
      sweep2($sformatf("rand2_%0d", n), l2, e2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_param_variant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
